// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and a 4-digit
// operand shift register (newest digit in X[3:0]).
// Optional feature macro: KEYPAD_HEX_EN. When defined, keys A-F are accepted;
// otherwise only 0-9 are entered, and the remaining keys are debounced and
// released silently.
`timescale 1ns/1ps
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 20000
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic [3:0]  ROW,
   input  logic        ENTRY_CLR,
   output logic [3:0]  COL,
   output logic [15:0] X,
   output logic [3:0]  KEY_CODE,
   output logic        KEY_VALID
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CNT);

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_ACCEPT,
      S_HELD
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [DIV_W-1:0]   r_div;
   logic [DEB_W-1:0]   r_cnt;
   logic [1:0]         r_col;
   logic [3:0]         r_row;
   logic [15:0]        r_x;
   logic [3:0]         r_code;

   logic [3:0]         w_low;
   logic               w_one_low;
   logic               w_win_end;
   logic               w_match;
   logic               w_deb_done;
   logic               w_released;
   logic [3:0]         w_code;
   logic               w_key_ok;
   logic               w_accept;

   // Map the latched row pattern and column index to the key code.
   function automatic logic [3:0] key_lookup(input logic [3:0] row, input logic [1:0] col);
      logic [1:0] ri;
      logic [3:0] code;
      case (row)
         4'b1110: ri = 2'd0;
         4'b1101: ri = 2'd1;
         4'b1011: ri = 2'd2;
         default: ri = 2'd3;
      endcase
      case ({ri, col})
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h2;
         4'd2:    code = 4'h3;
         4'd3:    code = 4'hA;
         4'd4:    code = 4'h4;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h6;
         4'd7:    code = 4'hB;
         4'd8:    code = 4'h7;
         4'd9:    code = 4'h8;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hC;
         4'd12:   code = 4'hE;
         4'd13:   code = 4'h0;
         4'd14:   code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   assign w_low      = ~ROW;
   assign w_one_low  = (w_low != 4'h0) && ((w_low & 4'(w_low - 4'd1)) == 4'h0);
   assign w_win_end  = (r_div == DIV_W'(SCAN_DIV - 1));
   assign w_match    = (ROW == r_row);
   assign w_deb_done = (r_cnt == DEB_W'(DEBOUNCE_CNT - 1));
   assign w_released = (ROW == 4'hF);
   assign w_code     = key_lookup(r_row, r_col);
`ifdef KEYPAD_HEX_EN
   assign w_key_ok   = 1'b1;
`else
   assign w_key_ok   = (w_code <= 4'h9);
`endif
   assign w_accept   = (r_state == S_DEBOUNCE) && w_match && w_deb_done && w_key_ok;

   // State register.
   always_ff @(posedge CLK) begin
      if (CLR) r_state <= S_SCAN;
      else     r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_SCAN:     if (w_win_end && w_one_low) w_next = S_DEBOUNCE;
         S_DEBOUNCE: begin
            if (!w_match)        w_next = S_SCAN;
            else if (w_deb_done) w_next = w_key_ok ? S_ACCEPT : S_HELD;
         end
         S_ACCEPT:   w_next = S_HELD;
         S_HELD:     if (w_released && w_deb_done) w_next = S_SCAN;
         default:    w_next = S_SCAN;
      endcase
   end

   // Scan divider, column index, debounce counter and row latch.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_div <= '0;
         r_cnt <= '0;
         r_col <= '0;
         r_row <= '1;
      end else begin
         case (r_state)
            S_SCAN: begin
               if (w_win_end) begin
                  r_div <= '0;
                  if (w_one_low) begin
                     r_row <= ROW;
                     r_cnt <= '0;
                  end else begin
                     r_col <= r_col + 2'd1;
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            S_DEBOUNCE: begin
               // A mismatch restarts the window on the same column.
               if (!w_match || w_deb_done) r_cnt <= '0;
               else                        r_cnt <= r_cnt + DEB_W'(1);
               if (!w_match)               r_div <= '0;
            end
            S_ACCEPT: r_cnt <= '0;
            S_HELD: begin
               if (!w_released) begin
                  r_cnt <= '0;
               end else if (w_deb_done) begin
                  r_cnt <= '0;
                  r_div <= '0;
                  r_col <= r_col + 2'd1;
               end else begin
                  r_cnt <= r_cnt + DEB_W'(1);
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // Operand register and last-key code; a clear coinciding with an accept
   // is applied before the shift.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_x    <= '0;
         r_code <= '0;
      end else begin
         if (ENTRY_CLR && w_accept) r_x <= {12'h000, w_code};
         else if (ENTRY_CLR)        r_x <= '0;
         else if (w_accept)         r_x <= {r_x[11:0], w_code};
         if (w_accept)              r_code <= w_code;
      end
   end

   assign COL       = ~(4'b0001 << r_col);
   assign X         = r_x;
   assign KEY_CODE  = r_code;
   assign KEY_VALID = (r_state == S_ACCEPT);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3).
// A keypad model drives ROW from COL; expected {KEY_CODE, X} pairs are queued
// at stimulus time and popped by a monitor on every KEY_VALID pulse.
`timescale 1ns/1ps
module tb_keypad_scanner;

   logic        CLK = 1'b0;
   logic        CLR = 1'b1;
   logic        ENTRY_CLR = 1'b0;
   logic [3:0]  ROW;
   logic [3:0]  COL;
   logic [15:0] X;
   logic [3:0]  KEY_CODE;
   logic        KEY_VALID;

   logic        pressed = 1'b0;
   logic        bounce  = 1'b0;
   logic [3:0]  key_rows = 4'hF;
   int          key_col = 0;

   int          errors = 0;
   int          checks = 0;
   int          pulses = 0;
   logic        prev_valid = 1'b0;
   logic [19:0] exp_q[$];
   logic [19:0] mon_e;
   int          p0;

   always #5 CLK = ~CLK;

   // Keypad model: the pressed key pulls its row(s) low only while its column is driven.
   assign ROW = (pressed && !bounce && COL[key_col] == 1'b0) ? key_rows : 4'hF;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .CLK(CLK), .CLR(CLR), .ROW(ROW), .ENTRY_CLR(ENTRY_CLR),
      .COL(COL), .X(X), .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] rowpat(input int r);
      logic [3:0] p;
      p = 4'b0001 << r;
      return ~p;
   endfunction

   // Monitor: every pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (KEY_VALID) begin
         pulses++;
         check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got KEY_CODE=%0h X=%04h, expected no pulse", KEY_CODE, X);
         end else begin
            mon_e = exp_q.pop_front();
            check("key_code", {28'd0, KEY_CODE}, {28'd0, mon_e[19:16]});
            check("x_on_accept", {16'd0, X}, {16'd0, mon_e[15:0]});
         end
      end
      prev_valid = KEY_VALID;
   end

   // Press on the first cycle of a fresh scan window for column c.
   task automatic sync_press(input logic [3:0] rp, input int c);
      logic [3:0] prev;
      int n;
      prev = COL;
      n = 0;
      @(negedge CLK);
      while (!(COL[c] == 1'b0 && prev[c] == 1'b1) && n < 40) begin
         prev = COL;
         @(negedge CLK);
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL column_wait: got no window for col %0d, expected one within 40 cycles", c);
      end
      key_rows = rp;
      key_col  = c;
      pressed  = 1'b1;
   endtask

   task automatic wait_valid(input string name, input int exp_lat);
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!KEY_VALID && n < 60);
      check(name, n, exp_lat);
   endtask

   task automatic release_key();
      pressed  = 1'b0;
      key_rows = 4'hF;
      repeat (12) @(negedge CLK);
   endtask

   // 4 scan cycles to the sample, then 3 debounce cycles.
   task automatic press_accept(input int r, input int c, input logic [3:0] code,
                               input logic [15:0] expx, input int hold);
      exp_q.push_back({code, expx});
      sync_press(rowpat(r), c);
      wait_valid("accept_latency", 7);
      repeat (hold) @(negedge CLK);
      release_key();
   endtask

   task automatic entry_clear();
      ENTRY_CLR = 1'b1;
      @(negedge CLK);
      ENTRY_CLR = 1'b0;
      check("entry_clr_alone", {16'd0, X}, 32'h0000);
   endtask

   initial begin
      // 1. reset state and idle column scan
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      CLR = 1'b0;
      check("rst_col", {28'd0, COL}, 32'hE);
      check("rst_x", {16'd0, X}, 32'h0);
      check("rst_code", {28'd0, KEY_CODE}, 32'h0);
      check("rst_valid", {31'd0, KEY_VALID}, 32'h0);
      repeat (4) @(negedge CLK); check("scan_col1", {28'd0, COL}, 32'hD);
      repeat (4) @(negedge CLK); check("scan_col2", {28'd0, COL}, 32'hB);
      repeat (4) @(negedge CLK); check("scan_col3", {28'd0, COL}, 32'h7);
      repeat (4) @(negedge CLK); check("scan_wrap", {28'd0, COL}, 32'hE);

      // 2. '5' held for 100 cycles: exactly one pulse
      press_accept(1, 1, 4'h5, 16'h0005, 100);
      check("no_repeat", pulses, 1);

      // 3. digit entry 1..5
      entry_clear();
      press_accept(0, 0, 4'h1, 16'h0001, 3);
      press_accept(0, 1, 4'h2, 16'h0012, 3);
      press_accept(0, 2, 4'h3, 16'h0123, 3);
      press_accept(1, 0, 4'h4, 16'h1234, 3);
      press_accept(1, 1, 4'h5, 16'h2345, 3);

      // 4. '7' bounces high on the third sample; window restarts on the same column
      exp_q.push_back({4'h7, 16'h3457});
      sync_press(rowpat(2), 0);
      repeat (5) @(negedge CLK);
      bounce = 1'b1;
      @(negedge CLK);
      bounce = 1'b0;
      wait_valid("bounce_latency", 7);
      release_key();

      // 5. ENTRY_CLR on the accept edge of '9' with X=1234
      entry_clear();
      press_accept(0, 0, 4'h1, 16'h0001, 3);
      press_accept(0, 1, 4'h2, 16'h0012, 3);
      press_accept(0, 2, 4'h3, 16'h0123, 3);
      press_accept(1, 0, 4'h4, 16'h1234, 3);
      exp_q.push_back({4'h9, 16'h0009});
      sync_press(rowpat(2), 2);
      repeat (6) @(negedge CLK);
      ENTRY_CLR = 1'b1;
      @(negedge CLK);
      ENTRY_CLR = 1'b0;
      check("clr_shift_valid", {31'd0, KEY_VALID}, 32'd1);
      repeat (2) @(negedge CLK);
      check("x_after_clr_shift", {16'd0, X}, 32'h0009);
      release_key();

      // 6a. two rows low on one column: ignored, scan keeps moving
      p0 = pulses;
      sync_press(4'b1100, 2);
      check("multi_col_now", {28'd0, COL}, 32'hB);
      repeat (4) @(negedge CLK);
      check("multi_scan_continues", {28'd0, COL}, 32'h7);
      repeat (26) @(negedge CLK);
      check("multi_no_pulse", pulses, p0);
      release_key();

      // 6b. CLR while '8' is held, then re-accept once
      exp_q.push_back({4'h8, 16'h0098});
      sync_press(rowpat(2), 1);
      wait_valid("accept_latency_8", 7);
      repeat (5) @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
      check("clr_col", {28'd0, COL}, 32'hE);
      check("clr_x", {16'd0, X}, 32'h0);
      check("clr_code", {28'd0, KEY_CODE}, 32'h0);
      check("clr_valid", {31'd0, KEY_VALID}, 32'h0);
      exp_q.push_back({4'h8, 16'h0008});
      wait_valid("reaccept_latency", 11);
      repeat (3) @(negedge CLK);
      release_key();

      // 6c. key 'A'
`ifdef KEYPAD_HEX_EN
      press_accept(0, 3, 4'hA, 16'h008A, 3);
`else
      p0 = pulses;
      sync_press(rowpat(0), 3);
      repeat (20) @(negedge CLK);
      check("hex_no_pulse", pulses, p0);
      release_key();
      check("hex_x_kept", {16'd0, X}, 32'h0008);
      check("hex_code_kept", {28'd0, KEY_CODE}, 32'h8);
      press_accept(1, 0, 4'h4, 16'h0084, 3);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
